pillar_animator: RTL and testbench

- Downstream consumer of the game-state controller's startAnimation output; returns doneAnimation to it.
- On start, raises the pillar one pixel row per animation frame by writing new pillar-top rows into the frame buffer.
- Drives a plot port (plotX/plotY/plotColour/plotEn) that is muxed into the VGA adapter write port beside the map drawer.
- Exports the current pillar top Y for collision/walkable logic.

---
 rtl/pillar_animator_if.sv | 38 +++
 rtl/pillar_animator.sv | 102 ++++++++++
 tb/tb_pillar_animator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pillar_animator_if.sv
// Plot/handshake bundle between the pillar animator, the game-state controller
// and the VGA write-port mux.
//   startAnimation : controller -> animator, level request to begin raising
//   plotX/plotY    : pixel coordinate to write (9-bit X, 8-bit Y)
//   plotColour     : pixel colour
//   plotEn         : write strobe, one pixel per cycle
//   doneAnimation  : animator -> controller, sticky completion level
//   pillarTop      : current pillar top row, used by collision/walkable logic
// modport master is the animator side, modport slave the consumer side.
interface pillar_animator_if;
  logic       startAnimation;
  logic [8:0] plotX;
  logic [7:0] plotY;
  logic [2:0] plotColour;
  logic       plotEn;
  logic       doneAnimation;
  logic [7:0] pillarTop;

  modport master (
    input  startAnimation,
    output plotX,
    output plotY,
    output plotColour,
    output plotEn,
    output doneAnimation,
    output pillarTop
  );

  modport slave (
    output startAnimation,
    input  plotX,
    input  plotY,
    input  plotColour,
    input  plotEn,
    input  doneAnimation,
    input  pillarTop
  );
endinterface

// File: rtl/pillar_animator.sv
// Pillar raise animation. After startAnimation, waits FRAME_TICKS cycles, then
// lifts the pillar top by one row and paints that new row (PILLAR_W pixels,
// one per cycle) until the top reaches TOP_END, then holds doneAnimation high.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high reset
//   bus   : pillar_animator_if.master (start in; plot port, done, pillarTop out)
module pillar_animator #(
  parameter int unsigned PILLAR_X    = 150,
  parameter int unsigned PILLAR_W    = 16,
  parameter int unsigned TOP_START   = 200,
  parameter int unsigned TOP_END     = 120,
  parameter int unsigned FRAME_TICKS = 833333,
  parameter logic [2:0]  COLOUR      = 3'b110
) (
  input logic                clock,
  input logic                reset,
  pillar_animator_if.master  bus
);

  // Counter only has to reach FRAME_TICKS-1.
  localparam int unsigned CntW = ($clog2(FRAME_TICKS) > 0) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_TICKS - 1);
  localparam logic [6:0]      IdxLast = 7'(PILLAR_W - 1);
  localparam logic [7:0]      TopStart = 8'(TOP_START);
  localparam logic [7:0]      TopEnd   = 8'(TOP_END);
  localparam logic [8:0]      BaseX    = 9'(PILLAR_X);

  typedef enum logic [1:0] {StIdle, StWait, StDraw, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [6:0]      idx_q;
  logic [7:0]      top_q;
  logic [8:0]      plot_x_q;
  logic [7:0]      plot_y_q;
  logic            plot_en_q;
  logic            done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      top_q     <= TopStart;
      plot_x_q  <= BaseX;
      plot_y_q  <= TopStart;
      plot_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.startAnimation) begin
            state_q <= StWait;
            cnt_q   <= '0;
          end
        end
        StWait: begin
          if (cnt_q == CntLast) begin
            // Raise the top and preload the first pixel of the new row so the
            // plot outputs come straight from registers during StDraw.
            state_q   <= StDraw;
            cnt_q     <= '0;
            idx_q     <= '0;
            top_q     <= top_q - 8'd1;
            plot_x_q  <= BaseX;
            plot_y_q  <= top_q - 8'd1;
            plot_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDraw: begin
          if (idx_q == IdxLast) begin
            plot_en_q <= 1'b0;
            if (top_q == TopEnd) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= '0;
            end
          end else begin
            idx_q    <= idx_q + 7'd1;
            plot_x_q <= plot_x_q + 9'd1;
          end
        end
        StDone: begin
          // Terminal until reset; doneAnimation stays high.
        end
      endcase
    end
  end

  assign bus.plotX         = plot_x_q;
  assign bus.plotY         = plot_y_q;
  assign bus.plotColour    = COLOUR;
  assign bus.plotEn        = plot_en_q;
  assign bus.doneAnimation = done_q;
  assign bus.pillarTop     = top_q;

endmodule

// File: tb/tb_pillar_animator.sv
// Bench for pillar_animator: two instances (a multi-row configuration and a
// minimal one-row configuration) share stimulus and are compared every cycle
// against a timing model derived from the row/frame arithmetic.
module tb_pillar_animator;

  logic clock = 1'b0;
  logic reset;
  logic start;

  always #5 clock = ~clock;

  pillar_animator_if ifa ();
  pillar_animator_if ifb ();

  assign ifa.startAnimation = start;
  assign ifb.startAnimation = start;

  pillar_animator #(
    .PILLAR_X(150), .PILLAR_W(3), .TOP_START(10), .TOP_END(7),
    .FRAME_TICKS(4), .COLOUR(3'b110)
  ) dut_a (
    .clock(clock),
    .reset(reset),
    .bus  (ifa.master)
  );

  pillar_animator #(
    .PILLAR_X(150), .PILLAR_W(1), .TOP_START(5), .TOP_END(4),
    .FRAME_TICKS(1), .COLOUR(3'b110)
  ) dut_b (
    .clock(clock),
    .reset(reset),
    .bus  (ifb.master)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: whether an animation is running and edges since the start edge.
  bit act [2];
  int k   [2];
  int pulses [2];

  function automatic int p_f(int d);  return (d == 0) ? 4 : 1;  endfunction
  function automatic int p_w(int d);  return (d == 0) ? 3 : 1;  endfunction
  function automatic int p_ts(int d); return (d == 0) ? 10 : 5; endfunction
  function automatic int p_te(int d); return (d == 0) ? 7 : 4;  endfunction
  function automatic int total(int d);
    return (p_ts(d) - p_te(d)) * (p_f(d) + p_w(d));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int d, output logic en, output logic done,
                         output logic [7:0] top, output logic [8:0] x,
                         output logic [7:0] y, output logic [2:0] c);
    if (d == 0) begin
      en = ifa.plotEn; done = ifa.doneAnimation; top = ifa.pillarTop;
      x = ifa.plotX; y = ifa.plotY; c = ifa.plotColour;
    end else begin
      en = ifb.plotEn; done = ifb.doneAnimation; top = ifb.pillarTop;
      x = ifb.plotX; y = ifb.plotY; c = ifb.plotColour;
    end
  endtask

  task automatic check_dut(input int d);
    logic en, done;
    logic [7:0] top, y;
    logic [8:0] x;
    logic [2:0] c;
    int e_en, e_done, e_top, e_x, r, m, per;
    string nm;
    nm = (d == 0) ? "A" : "B";
    per = p_f(d) + p_w(d);
    e_en = 0; e_done = 0; e_top = p_ts(d); e_x = 150;
    if (act[d]) begin
      if (k[d] >= total(d)) begin
        e_done = 1;
        e_top  = p_te(d);
      end else begin
        r = k[d] / per;
        m = k[d] % per;
        if (m < p_f(d)) begin
          e_top = p_ts(d) - r;
        end else begin
          e_en  = 1;
          e_top = p_ts(d) - r - 1;
          e_x   = 150 + m - p_f(d);
        end
      end
    end
    get_obs(d, en, done, top, x, y, c);
    chk($sformatf("%s.plotEn k=%0d", nm, k[d]), 32'(en), 32'(e_en));
    chk($sformatf("%s.doneAnimation k=%0d", nm, k[d]), 32'(done), 32'(e_done));
    chk($sformatf("%s.pillarTop k=%0d", nm, k[d]), 32'(top), 32'(e_top));
    if (e_en == 1) begin
      chk($sformatf("%s.plotX k=%0d", nm, k[d]), 32'(x), 32'(e_x));
      chk($sformatf("%s.plotY k=%0d", nm, k[d]), 32'(y), 32'(e_top));
      chk($sformatf("%s.plotColour", nm), 32'(c), 32'd6);
    end
    if (en === 1'b1) pulses[d]++;
  endtask

  task automatic check_reset_values(input int d);
    logic en, done;
    logic [7:0] top, y;
    logic [8:0] x;
    logic [2:0] c;
    get_obs(d, en, done, top, x, y, c);
    chk("rst.plotEn", 32'(en), 32'd0);
    chk("rst.doneAnimation", 32'(done), 32'd0);
    chk("rst.pillarTop", 32'(top), 32'(p_ts(d)));
    chk("rst.plotX", 32'(x), 32'd150);
    chk("rst.plotY", 32'(y), 32'(p_ts(d)));
    chk("rst.plotColour", 32'(c), 32'd6);
  endtask

  // One clock: advance the model at the posedge, compare at the negedge.
  task automatic step();
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      if (act[d]) begin
        if (k[d] < total(d)) k[d]++;
      end else if (start) begin
        act[d] = 1'b1;
        k[d]   = 0;
      end
    end
    @(negedge clock);
    check_dut(0);
    check_dut(1);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  // Reset pulse placed mid-cycle, well away from either clock edge.
  task automatic async_reset();
    #1 reset = 1'b1;
    #1;
    check_reset_values(0);
    check_reset_values(1);
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0;
      k[d] = 0;
      pulses[d] = 0;
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; k[d] = 0; pulses[d] = 0;
    end
    #2;
    check_reset_values(0);
    check_reset_values(1);
    @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;

    // No request: everything stays idle.
    cycles(100);

    // Single-cycle start pulse, run to completion.
    start = 1'b1;
    step();
    start = 1'b0;
    cycles(25);
    chk("A.pulse_count", 32'(pulses[0]), 32'd9);
    chk("B.pulse_count", 32'(pulses[1]), 32'd1);

    // Start held high through the whole run, dropped after done.
    async_reset();
    start = 1'b1;
    cycles(30);
    start = 1'b0;
    cycles(10);
    chk("A.pulse_count_held", 32'(pulses[0]), 32'd9);

    // Reset during the second row's draw, then a fresh run.
    async_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    cycles(12);
    chk("A.mid_second_row", 32'(ifa.plotEn), 32'd1);
    async_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    cycles(25);
    chk("A.pulse_count_rerun", 32'(pulses[0]), 32'd9);

    // Random start levels with occasional asynchronous resets.
    for (int it = 0; it < 20; it++) begin
      async_reset();
      start = 1'b0;
      cycles($urandom_range(0, 5));
      for (int c = 0; c < 40; c++) begin
        start = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 14) == 0) async_reset();
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
